// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter sharing the ALU operand path between requesters A and B.
// The winning operand is registered and offered to the ALU under valid/ready.
module alu_operand_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             s,
  output logic             ack_a,
  output logic             ack_b
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_o;
  logic             r_s;
  logic             r_last;
  logic             w_accept;
  logic             w_eligA;
  logic             w_eligB;
  logic             w_capture;
  logic             w_pickA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // At an accept edge the requester being served still shows its old request,
  // so only the other side may be captured back-to-back.
  always_comb begin
    w_nextState = r_state;
    w_accept    = (r_state == BUSY) & o_ready;
    w_eligA     = req_a & ((r_state == IDLE) | (w_accept & ~r_s));
    w_eligB     = req_b & ((r_state == IDLE) | (w_accept & r_s));
    w_capture   = w_eligA | w_eligB;
    w_pickA     = w_eligA & (~w_eligB | ~r_last);
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && !w_capture) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o    <= '0;
      r_s    <= 1'b0;
      r_last <= 1'b0;
    end else begin
      if (w_capture) begin
        r_o <= w_pickA ? a : b;
        r_s <= w_pickA;
      end
      if (w_accept) begin
        r_last <= r_s;
      end
    end
  end

  assign o       = r_o;
  assign s       = r_s;
  assign o_valid = (r_state == BUSY);
  assign ack_a   = o_valid & o_ready & r_s;
  assign ack_b   = o_valid & o_ready & ~r_s;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Scoreboard bench for alu_operand_arbiter: expected transfers are queued as
// stimulus is driven and retired whenever the ALU side accepts an operand.
module tb_alu_operand_arbiter;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } expEntry_t;

  logic       clk;
  logic       rst;
  logic       reqA;
  logic [7:0] dataA;
  logic       reqB;
  logic [7:0] dataB;
  logic [7:0] o;
  logic       oValid;
  logic       oReady;
  logic       s;
  logic       ackA;
  logic       ackB;

  expEntry_t  expQ[$];
  expEntry_t  popped;
  int         nCompared;
  int         nMismatched;

  alu_operand_arbiter #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (reqA),
    .a       (dataA),
    .req_b   (reqB),
    .b       (dataB),
    .o       (o),
    .o_valid (oValid),
    .o_ready (oReady),
    .s       (s),
    .ack_a   (ackA),
    .ack_b   (ackB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [7:0] da, input logic rb, input logic [7:0] db, input logic rdy);
    @(posedge clk);
    #1;
    reqA   = ra;
    dataA  = da;
    reqB   = rb;
    dataB  = db;
    oReady = rdy;
  endtask

  task automatic pushExp(input logic owner, input logic [7:0] data);
    expEntry_t e;
    e.owner = owner;
    e.data  = data;
    expQ.push_back(e);
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every accepted transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (oValid && oReady) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousXfer", 32'd1, 32'd0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("xferData", {24'd0, o}, {24'd0, popped.data});
          checkOutput("xferOwner", {31'd0, s}, {31'd0, popped.owner});
          checkOutput("xferAckA", {31'd0, ackA}, {31'd0, popped.owner});
          checkOutput("xferAckB", {31'd0, ackB}, {31'd0, ~popped.owner});
        end
      end else begin
        checkOutput("ackIdle", {30'd0, ackA, ackB}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst    = 1'b1;
    reqA   = 1'b0;
    dataA  = 8'h00;
    reqB   = 1'b0;
    dataB  = 8'h00;
    oReady = 1'b0;
    #2;
    checkOutput("rstO", {24'd0, o}, 32'h00);
    checkOutput("rstValid", {31'd0, oValid}, 32'd0);
    checkOutput("rstS", {31'd0, s}, 32'd0);
    checkOutput("rstAck", {30'd0, ackA, ackB}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of a pending transfer must drop it silently.
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midHeldValid", {31'd0, oValid}, 32'd1);
    checkOutput("midHeldS", {31'd0, s}, 32'd1);
    checkOutput("midHeldO", {24'd0, o}, 32'h5A);
    #2;
    rst    = 1'b1;
    oReady = 1'b1;
    #1;
    checkOutput("midRstO", {24'd0, o}, 32'h00);
    checkOutput("midRstValid", {31'd0, oValid}, 32'd0);
    checkOutput("midRstS", {31'd0, s}, 32'd0);
    checkOutput("midRstAck", {30'd0, ackA, ackB}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Single requester A with the ALU always ready.
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    pushExp(1'b1, 8'h3C);
    @(negedge clk);
    checkOutput("aLatency", {31'd0, oValid}, 32'd0);
    @(negedge clk);
    checkOutput("aValid", {31'd0, oValid}, 32'd1);
    checkOutput("aAck", {31'd0, ackA}, 32'd1);
    @(negedge clk);
    checkOutput("aIneligible", {31'd0, oValid}, 32'd0);
    #1;
    reqA = 1'b0;

    // Tie straight after reset: A first, then strict alternation.
    resetPulse();
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 3; i++) begin
      pushExp(1'b1, 8'h11);
      pushExp(1'b0, 8'h22);
    end
    repeat (7) @(negedge clk);
    #1;
    reqA = 1'b0;
    reqB = 1'b0;
    @(negedge clk);
    checkOutput("tieDrain", {31'd0, oValid}, 32'd0);

    // Backpressure on B for five cycles.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hF0, 1'b0);
    pushExp(1'b0, 8'hF0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpValid", {31'd0, oValid}, 32'd1);
      checkOutput("bpData", {24'd0, o}, 32'hF0);
      checkOutput("bpS", {31'd0, s}, 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hF0, 1'b1);
    @(negedge clk);
    checkOutput("bpAckB", {31'd0, ackB}, 32'd1);
    #1;
    reqB = 1'b0;
    @(negedge clk);
    checkOutput("bpDrain", {31'd0, oValid}, 32'd0);

    // A arrives while B is stalled and is captured at B's accept edge.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hF0, 1'b0);
    pushExp(1'b0, 8'hF0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 8'hA5, 1'b1, 8'hF0, 1'b0);
    pushExp(1'b1, 8'hA5);
    @(negedge clk);
    checkOutput("lateHoldS", {31'd0, s}, 32'd0);
    @(negedge clk);
    checkOutput("lateHoldO", {24'd0, o}, 32'hF0);
    applyStimulus(1'b1, 8'hA5, 1'b1, 8'hF0, 1'b1);
    @(negedge clk);
    #1;
    reqB = 1'b0;
    @(negedge clk);
    checkOutput("lateB2BValid", {31'd0, oValid}, 32'd1);
    checkOutput("lateB2BS", {31'd0, s}, 32'd1);
    #1;
    reqA = 1'b0;
    @(negedge clk);
    checkOutput("lateDrain", {31'd0, oValid}, 32'd0);

    // One continuous requester gets an ack every second cycle.
    applyStimulus(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      pushExp(1'b1, 8'h77);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("contAckA", {31'd0, ackA}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    #1;
    reqA = 1'b0;
    @(negedge clk);
    checkOutput("contDrain", {31'd0, oValid}, 32'd0);

    @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_operand_arbiter.md
# alu_operand_arbiter

Two-requester round-robin arbiter that shares the projectALU 8-bit operand path between requesters A and B. It selects one requester's operand with the same select convention as the 2:1 operand mux (s=1 selects A, s=0 selects B). It registers the operand and presents it to the ALU under a valid/ready handshake. It strobes an acknowledge back to the served requester on transfer.

## Interface
- WIDTH, 8, operand width in bits.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A has an operand pending; held high with a stable until ack_a.
- a  input  WIDTH  requester A operand.
- req_b  input  1  requester B has an operand pending; held high with a stable b until ack_b.
- b  input  WIDTH  requester B operand.
- o  output  WIDTH  registered operand presented to the ALU.
- o_valid  output  1  o holds an operand awaiting acceptance.
- o_ready  input  1  ALU accepts o in any cycle where o_valid & o_ready.
- s  output  1  registered owner/select: 1 = o came from A, 0 = from B; meaningful only while o_valid.
- ack_a  output  1  combinational strobe, o_valid & o_ready & s.
- ack_b  output  1  combinational strobe, o_valid & o_ready & ~s.

## Operation
- States:
  - IDLE (o_valid=0).
  - BUSY (o_valid=1).
- Internal 1-bit pointer `last` records the most recently served requester. Reset value = B, so A wins the first tie.
- IDLE:
  - On a clock edge with req_a|req_b, capture the winning operand into o. Set s to the winner and o_valid=1, then go to BUSY.
  - With only one request, that requester wins.
  - With both requests, the requester ≠ last wins.
  - With no request, stay in IDLE; o, s and o_valid are unchanged.
- BUSY, no accept (o_ready=0): o, s and o_valid are held and the inputs are ignored. Requests accumulate with no loss of fairness.
- BUSY, accept edge (o_valid & o_ready):
  - last <= s.
  - The just-served requester is ineligible at this edge; its req and data are still the old transaction.
  - If the other requester is requesting, capture its operand at this same edge (back-to-back): s flips and o_valid stays 1.
  - Otherwise o_valid <= 0 and go to IDLE.
  - o retains its last value when idle.
- The served requester becomes eligible again from the cycle after its ack. It may drop req or present new data on that cycle.
- Exactly one of ack_a/ack_b is high per accepted transfer; they are never both high.
- No arithmetic. o is a straight WIDTH-bit copy of the selected input.

## Timing
- Reset (asynchronous, immediate): o=0, o_valid=0, s=0, last=B, state IDLE; ack_a=ack_b=0.
- Reset asserted mid-transaction drops the pending operand without an ack. Requesters retry after reset release.
- Latency: request sampled at edge N → o/o_valid/s valid after edge N (visible in cycle N+1).
- Minimum accept-to-ack: ack is asserted in the same cycle the ALU sees o_valid & o_ready.
- Throughput:
  - With both requesters continuously requesting and o_ready=1, one transfer per cycle, strictly alternating A, B, A, B.
  - With a single continuous requester, one transfer every 2 cycles, because of the ineligible-at-ack rule.
- Requests that change while in BUSY without accept have no effect until the next capture edge.

## Test plan
- Reset value check: assert rst mid-cycle with o_valid=1, s=1, o=8'h5A → o=8'h00, o_valid=0, s=0 immediately, and no ack.
- Single A: req_a=1, a=8'h3C, o_ready=1 → next cycle o=8'h3C, s=1, o_valid=1, ack_a=1; the following cycle o_valid=0 with req_a still high.
- Tie after reset: req_a=req_b=1, a=8'h11, b=8'h22, o_ready=1 → transfers 8'h11 (s=1), 8'h22 (s=0), 8'h11 … on consecutive cycles, with ack_a/ack_b alternating.
- Backpressure: req_b=1, b=8'hF0, o_ready=0 for 5 cycles, then 1 → o=8'hF0, s=0, o_valid=1 held for all 5 cycles; ack_b only in the ready cycle.
- Late arrival fairness: while B is stalled on o_ready=0, req_a rises → when o_ready=1 at B's accept edge, A is captured at the same edge (o_valid stays 1, s becomes 1).
- Single continuous requester: req_a=1 permanently, o_ready=1 → ack_a every second cycle, never two in consecutive cycles.
